// File: rtl/seg7_scan_reader.sv
// Recovers BCD frames from a multiplexed active-low 4-digit 7-segment bus.
// Synchronize, stability-filter, decode, then hand out frames over valid/ready.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [15:0] frame_digits,
    output logic [3:0]  frame_blank,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    logic [10:0]      r_sync1;
    logic [10:0]      r_sync2;
    logic [10:0]      r_prev;
    logic [7:0]       r_stab_cnt;
    logic             r_armed;
    logic [3:0]       r_mask;
    logic [3:0][3:0]  r_dig;
    logic [3:0]       r_blank;
    logic [3:0]       r_err;
    logic             r_frame_valid;
    logic [15:0]      r_frame_digits;
    logic [3:0]       r_frame_blank;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_same;
    logic [7:0]       w_cnt_inc;
    logic             w_fire;
    logic [3:0]       w_an_low;
    logic             w_one_hot;
    logic             w_cap;
    logic [6:0]       w_seg;
    logic [3:0]       w_dec_dig;
    logic             w_dec_blank;
    logic             w_dec_err;
    logic [3:0][3:0]  w_dig_n;
    logic [3:0]       w_blank_n;
    logic [3:0]       w_err_n;
    logic [3:0]       w_mask_n;
    logic             w_done;
    logic             w_accept;
    logic             w_load;

    assign w_same    = (r_sync2 == r_prev);
    assign w_cnt_inc = (r_stab_cnt == 8'hFF) ? 8'hFF : r_stab_cnt + 8'd1;
    assign w_fire    = r_armed && w_same && (w_cnt_inc == LP_STABLE);
    assign w_an_low  = ~r_sync2[3:0];
    assign w_one_hot = (w_an_low != 4'b0000)
                    && ((w_an_low & (w_an_low - 4'd1)) == 4'b0000);
    assign w_cap     = w_fire && w_one_hot;
    assign w_seg     = r_sync2[10:4];

    always_comb begin
        w_dec_dig   = 4'hE;
        w_dec_blank = 1'b0;
        w_dec_err   = 1'b0;
        case (w_seg)
            7'b0000001: w_dec_dig = 4'd0;
            7'b1001111: w_dec_dig = 4'd1;
            7'b0010010: w_dec_dig = 4'd2;
            7'b0000110: w_dec_dig = 4'd3;
            7'b1001100: w_dec_dig = 4'd4;
            7'b0100100: w_dec_dig = 4'd5;
            7'b0100000: w_dec_dig = 4'd6;
            7'b0001111: w_dec_dig = 4'd7;
            7'b0000000: w_dec_dig = 4'd8;
            7'b0000100: w_dec_dig = 4'd9;
            7'b1111111: begin
                w_dec_dig   = 4'hF;
                w_dec_blank = 1'b1;
            end
            default:    w_dec_err = 1'b1;
        endcase
    end

    // Slot contents including the capture of this cycle, so a completing
    // capture lands in the same frame it completes.
    always_comb begin
        w_dig_n   = r_dig;
        w_blank_n = r_blank;
        w_err_n   = r_err;
        for (int i = 0; i < 4; i++) begin
            if (w_cap && w_an_low[i]) begin
                w_dig_n[i]   = w_dec_dig;
                w_blank_n[i] = w_dec_blank;
                w_err_n[i]   = w_dec_err;
            end
        end
    end

    assign w_mask_n = r_mask | (w_cap ? w_an_low : 4'b0000);
    assign w_done   = w_cap && (w_mask_n == 4'hF);
    assign w_accept = r_frame_valid && frame_ready;
    assign w_load   = w_done && (!r_frame_valid || frame_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_prev         <= '1;
            r_stab_cnt     <= '0;
            r_armed        <= 1'b0;
            r_mask         <= '0;
            r_dig          <= '0;
            r_blank        <= '0;
            r_err          <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_digits <= '0;
            r_frame_blank  <= '0;
            r_frame_err    <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sync1 <= {seg_n, an_n};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_same) begin
                r_stab_cnt <= 8'd1;
                r_armed    <= 1'b1;
            end else begin
                r_stab_cnt <= w_cnt_inc;
                if (w_fire) r_armed <= 1'b0;
            end
            r_dig   <= w_dig_n;
            r_blank <= w_blank_n;
            r_err   <= w_err_n;
            r_mask  <= w_done ? 4'b0000 : w_mask_n;
            if (w_load) begin
                r_frame_valid  <= 1'b1;
                r_frame_digits <= w_dig_n;
                r_frame_blank  <= w_blank_n;
                r_frame_err    <= |w_err_n;
            end else if (w_accept) begin
                r_frame_valid  <= 1'b0;
            end
            if (w_accept) r_overrun <= 1'b0;
            else if (w_done && !w_load) r_overrun <= 1'b1;
        end
    end

    assign frame_valid  = r_frame_valid;
    assign frame_digits = r_frame_digits;
    assign frame_blank  = r_frame_blank;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: run-length reference model compared every
// cycle, directed scenarios with literal expectations, then random scans.
module tb_seg7_scan_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_ready;
    logic        frame_valid;
    logic [15:0] frame_digits;
    logic [3:0]  frame_blank;
    logic        frame_err;
    logic        overrun;

    seg7_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .frame_ready(frame_ready), .frame_valid(frame_valid),
        .frame_digits(frame_digits), .frame_blank(frame_blank),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                              7'b0000110, 7'b1001100, 7'b0100100,
                              7'b0100000, 7'b0001111, 7'b0000000,
                              7'b0000100};

    int n_cmp = 0;
    int n_bad = 0;
    logic rnd_ready = 1'b0;
    logic [20:0] dut_q[$];

    // Reference model state
    logic [10:0] m_s1 = '0, m_s2 = '0, m_prev = '1;
    int          m_run = 0;
    logic [3:0]  m_dig [4];
    logic        m_blk [4];
    logic        m_er  [4];
    logic [3:0]  m_mask = '0;
    logic        e_valid = 1'b0;
    logic [15:0] e_dig = '0;
    logic [3:0]  e_blk = '0;
    logic        e_err = 1'b0;
    logic        e_ovr = 1'b0;
    int          m_caps = 0;
    int          m_raw = 0;

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '1; m_run = 0; m_mask = '0;
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = '0; m_blk[k] = 1'b0; m_er[k] = 1'b0;
        end
        e_valid = 1'b0; e_dig = '0; e_blk = '0; e_err = 1'b0; e_ovr = 1'b0;
    endtask

    task automatic m_step();
        logic [10:0] s;
        logic [3:0]  low;
        logic [3:0]  dd;
        logic        bb, ee, done;
        int          idx;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = {seg_n, an_n};
        if (s != m_prev) m_run = 1;
        else m_run++;
        m_prev = s;
        done = 1'b0;
        if (m_run == STABLE) begin
            m_raw++;
            low = ~s[3:0];
            if ($countones(low) == 1) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (low[k]) idx = k;
                dd = 4'hE; bb = 1'b0; ee = 1'b1;
                if (s[10:4] == 7'h7F) begin
                    dd = 4'hF; bb = 1'b1; ee = 1'b0;
                end
                for (int k = 0; k < 10; k++)
                    if (s[10:4] == pats[k]) begin
                        dd = 4'(k); ee = 1'b0;
                    end
                m_dig[idx] = dd; m_blk[idx] = bb; m_er[idx] = ee;
                m_mask[idx] = 1'b1;
                m_caps++;
                if (m_mask == 4'hF) begin
                    done = 1'b1;
                    m_mask = '0;
                end
            end
        end
        if (e_valid && frame_ready) begin
            e_valid = 1'b0;
            e_ovr = 1'b0;
        end
        if (done) begin
            if (!e_valid) begin
                e_valid = 1'b1;
                e_dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                e_blk = {m_blk[3], m_blk[2], m_blk[1], m_blk[0]};
                e_err = m_er[3] | m_er[2] | m_er[1] | m_er[0];
            end else begin
                e_ovr = 1'b1;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if ({frame_valid, frame_digits, frame_blank, frame_err, overrun}
                !== {e_valid, e_dig, e_blk, e_err, e_ovr}) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t got v%b d%h b%b e%b o%b want v%b d%h b%b e%b o%b",
                         $time, frame_valid, frame_digits, frame_blank,
                         frame_err, overrun, e_valid, e_dig, e_blk, e_err,
                         e_ovr);
            end
            if (rst_n && frame_valid && frame_ready)
                dut_q.push_back({frame_digits, frame_blank, frame_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) frame_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic scan(int d, logic [6:0] p, int hold);
        an_n = ~(4'b0001 << d);
        seg_n = p;
        repeat (hold) tick();
        an_n = 4'hF;
        repeat (3) tick();
    endtask

    task automatic expect_frame(string nm, logic [15:0] d, logic [3:0] b,
                                logic e);
        int w;
        logic [20:0] f;
        w = 0;
        while (dut_q.size() == 0 && w < 60) begin
            tick();
            w++;
        end
        n_cmp++;
        if (dut_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s no frame in 60 cycles want %h", nm, d);
        end else begin
            f = dut_q.pop_front();
            if (f !== {d, b, e}) begin
                n_bad++;
                $display("FAIL %s got %h/%b/%b want %h/%b/%b", nm,
                         f[20:5], f[4:1], f[0], d, b, e);
            end
        end
    endtask

    initial begin
        int c0, r0, hold;
        logic [6:0] p;
        rst_n = 1'b0;
        seg_n = 7'h7F;
        an_n = 4'hF;
        frame_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs",
            {9'd0, frame_valid, frame_digits, frame_blank, frame_err, overrun},
            32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        scan(3, pats[1], 10);
        scan(2, pats[2], 10);
        scan(1, pats[3], 10);
        scan(0, pats[4], 10);
        expect_frame("clean_scan", 16'h1234, 4'b0000, 1'b0);
        chk("clean_single", dut_q.size(), 0);

        c0 = m_caps;
        an_n = 4'b1110;
        seg_n = pats[0];
        repeat (10) tick();
        seg_n = pats[8];
        repeat (2) tick();
        seg_n = pats[0];
        repeat (10) tick();
        an_n = 4'hF;
        repeat (3) tick();
        chk("glitch_caps", m_caps - c0, 2);
        scan(3, pats[1], 10);
        scan(2, pats[2], 10);
        scan(1, pats[3], 10);
        expect_frame("glitch_frame", 16'h1230, 4'b0000, 1'b0);

        scan(3, 7'b1111111, 10);
        scan(2, 7'b1010101, 10);
        scan(1, pats[9], 10);
        scan(0, pats[5], 10);
        expect_frame("blank_illegal", 16'hFE95, 4'b1000, 1'b1);

        frame_ready = 1'b0;
        for (int k = 3; k >= 0; k--) scan(k, pats[1], 10);
        for (int k = 3; k >= 0; k--) scan(k, pats[2], 10);
        chk("bp_valid", frame_valid, 1);
        chk("bp_hold", frame_digits, 16'h1111);
        chk("bp_overrun", overrun, 1);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("bp_drop_valid", frame_valid, 0);
        chk("bp_clr_overrun", overrun, 0);
        expect_frame("bp_accepted", 16'h1111, 4'b0000, 1'b0);
        frame_ready = 1'b1;

        repeat (10) tick();
        c0 = m_caps;
        r0 = m_raw;
        an_n = 4'b1100;
        seg_n = pats[1];
        repeat (20) tick();
        an_n = 4'hF;
        repeat (3) tick();
        chk("multi_an_caps", m_caps - c0, 0);
        chk("multi_an_raw", m_raw - r0, 1);
        scan(0, pats[3], 10);
        scan(0, pats[7], 10);
        scan(3, pats[4], 10);
        scan(2, pats[5], 10);
        scan(1, pats[6], 10);
        expect_frame("overwrite", 16'h4567, 4'b0000, 1'b0);

        scan(3, pats[9], 10);
        scan(2, pats[8], 10);
        scan(1, pats[7], 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_outputs",
            {9'd0, frame_valid, frame_digits, frame_blank, frame_err, overrun},
            32'd0);
        scan(0, pats[0], 10);
        repeat (10) tick();
        chk("midreset_noframe", {31'd0, frame_valid} + dut_q.size(), 0);
        scan(3, pats[1], 10);
        scan(2, pats[2], 10);
        scan(1, pats[3], 10);
        expect_frame("midreset_frame", 16'h1230, 4'b0000, 1'b0);

        rnd_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0)
                an_n = 4'($urandom_range(0, 15));
            else
                an_n = ~(4'b0001 << $urandom_range(0, 3));
            case ($urandom_range(0, 9))
                7: p = 7'h7F;
                8, 9: p = 7'($urandom_range(0, 127));
                default: p = pats[$urandom_range(0, 9)];
            endcase
            seg_n = p;
            hold = $urandom_range(1, 12);
            repeat (hold) tick();
            an_n = 4'hF;
            repeat ($urandom_range(0, 4)) tick();
        end
        rnd_ready = 1'b0;
        frame_ready = 1'b1;
        repeat (20) tick();
        dut_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
